// File: rtl/codec_serial_intf.sv
// codec_serial_intf
// I2S-style serial interface between the equalizer datapath and an external
// audio codec. One free-running counter produces the codec clocks (MCLK, SCL,
// LRCLK) and paces both directions of the serial link. Received left/right
// samples are presented as parallel words with a one-cycle valid strobe.
// Parallel transmit words, or the words just received when loopback is set,
// are shifted out on SDin during the following frame.
//
// Ports
//   clk       system clock, all logic on the rising edge
//   RST       synchronous active-high reset
//   loopback  1: retransmit received words, 0: transmit lft_in/rht_in
//   lft_in    left transmit sample
//   rht_in    right transmit sample
//   lft_out   last complete received left sample
//   rht_out   last complete received right sample
//   valid     one-cycle strobe when lft_out/rht_out update
//   MCLK      codec master clock (counter bit MCLK_BIT)
//   SCL       codec bit clock (counter bit SCL_BIT)
//   LRCLK     codec word clock, 0 = left half, 1 = right half
//   RSTn      codec reset, active low
//   SDin      serial data towards the codec
//   SDout     serial data from the codec
module codec_serial_intf #(
  parameter int DATA_W   = 24,
  parameter int MCLK_BIT = 1,
  parameter int SCL_BIT  = 4
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              loopback,
  input  logic [DATA_W-1:0] lft_in,
  input  logic [DATA_W-1:0] rht_in,
  output logic [DATA_W-1:0] lft_out,
  output logic [DATA_W-1:0] rht_out,
  output logic              valid,
  output logic              MCLK,
  output logic              SCL,
  output logic              LRCLK,
  output logic              RSTn,
  output logic              SDin,
  input  logic              SDout
);

  localparam int CntW = SCL_BIT + 7;

  // Position inside one SCL period: the last low-phase cycle (SCL about to
  // rise), the first high-phase cycle, and the last high-phase cycle (SCL
  // about to fall).
  localparam logic [SCL_BIT:0] CapPhase   = {1'b0, {SCL_BIT{1'b1}}};
  localparam logic [SCL_BIT:0] LoadPhase  = {1'b1, {SCL_BIT{1'b0}}};
  localparam logic [SCL_BIT:0] DrivePhase = {(SCL_BIT + 1){1'b1}};
  localparam logic [4:0]       LastSlot   = 5'(DATA_W);

  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] lftShift_q, lftShift_d;
  logic [DATA_W-1:0] rhtShift_q, rhtShift_d;
  logic [DATA_W-1:0] txLft_q, txLft_d;
  logic [DATA_W-1:0] txRht_q, txRht_d;
  logic [DATA_W-1:0] lftOut_q, lftOut_d;
  logic [DATA_W-1:0] rhtOut_q, rhtOut_d;
  logic              valid_q, valid_d;
  logic              rstn_q, rstn_d;
  logic              sdin_q, sdin_d;

  logic [4:0]        curSlot, nxtSlot, bitIdx;
  logic              curHalf, nxtHalf;
  logic              captureEn, loadEn, sdBit;
  logic [DATA_W-1:0] txWord;

  // Next-state logic for the whole block, driven by the counter position.
  always_comb begin
    cnt_d   = cnt_q + CntW'(1);
    curSlot = cnt_q[SCL_BIT+5:SCL_BIT+1];
    curHalf = cnt_q[SCL_BIT+6];
    nxtSlot = cnt_d[SCL_BIT+5:SCL_BIT+1];
    nxtHalf = cnt_d[SCL_BIT+6];

    // Slot 0 is the I2S one-bit delay and slots past the LSB are padding.
    captureEn = (cnt_q[SCL_BIT:0] == CapPhase) && (curSlot != 5'd0) &&
                (curSlot <= LastSlot);
    // The cycle right after the right-channel LSB has been captured.
    loadEn    = curHalf && (curSlot == LastSlot) &&
                (cnt_q[SCL_BIT:0] == LoadPhase);

    lftShift_d = lftShift_q;
    rhtShift_d = rhtShift_q;
    if (captureEn) begin
      if (curHalf) begin
        rhtShift_d = (rhtShift_q << 1) | DATA_W'(SDout);
      end else begin
        lftShift_d = (lftShift_q << 1) | DATA_W'(SDout);
      end
    end

    // The codec is still held in reset during the first frame, so that frame
    // is not reported; the transmit side loads regardless.
    lftOut_d = lftOut_q;
    rhtOut_d = rhtOut_q;
    valid_d  = loadEn && rstn_q;
    if (loadEn && rstn_q) begin
      lftOut_d = lftShift_q;
      rhtOut_d = rhtShift_q;
    end

    txLft_d = txLft_q;
    txRht_d = txRht_q;
    if (loadEn) begin
      txLft_d = loopback ? lftShift_q : lft_in;
      txRht_d = loopback ? rhtShift_q : rht_in;
    end

    // SDin is registered one cycle early, so it is computed for the slot the
    // counter is about to enter. Loads only happen after the last data slot
    // of the right half, so a new word first appears in the next left half.
    txWord = nxtHalf ? txRht_q : txLft_q;
    bitIdx = LastSlot - nxtSlot;
    sdBit  = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      if (bitIdx == 5'(i)) sdBit = txWord[i];
    end
    sdin_d = sdin_q;
    if (cnt_q[SCL_BIT:0] == DrivePhase) begin
      sdin_d = (nxtSlot != 5'd0) && (nxtSlot <= LastSlot) && sdBit;
    end

    // Codec reset releases on the first wrap and then stays released.
    rstn_d = rstn_q | (&cnt_q);
  end

  // State registers; RST overrides every other update.
  always_ff @(posedge clk) begin
    if (RST) begin
      cnt_q      <= '0;
      lftShift_q <= '0;
      rhtShift_q <= '0;
      txLft_q    <= '0;
      txRht_q    <= '0;
      lftOut_q   <= '0;
      rhtOut_q   <= '0;
      valid_q    <= 1'b0;
      rstn_q     <= 1'b0;
      sdin_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      lftShift_q <= lftShift_d;
      rhtShift_q <= rhtShift_d;
      txLft_q    <= txLft_d;
      txRht_q    <= txRht_d;
      lftOut_q   <= lftOut_d;
      rhtOut_q   <= rhtOut_d;
      valid_q    <= valid_d;
      rstn_q     <= rstn_d;
      sdin_q     <= sdin_d;
    end
  end

  assign MCLK    = cnt_q[MCLK_BIT];
  assign SCL     = cnt_q[SCL_BIT];
  assign LRCLK   = cnt_q[SCL_BIT+6];
  assign RSTn    = rstn_q;
  assign SDin    = sdin_q;
  assign valid   = valid_q;
  assign lft_out = lftOut_q;
  assign rht_out = rhtOut_q;

endmodule

// File: tb/tb_codec_serial_intf.sv
// Testbench for codec_serial_intf with default parameters (24-bit samples,
// 2048-clock frames). A frame-level model of the codec link runs alongside
// the DUT and checks every output on every cycle; directed checks with
// literal values pin the reset, receive, transmit and loopback behaviour.
module tb_codec_serial_intf;

  logic        clk = 1'b0;
  logic        RST;
  logic        loopback;
  logic [23:0] lft_in, rht_in;
  logic [23:0] lft_out, rht_out;
  logic        valid, MCLK, SCL, LRCLK, RSTn, SDin, SDout;

  // Words the bench codec sends; sampled by the model at each frame start.
  logic [23:0] codecL, codecR;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  codec_serial_intf #(
    .DATA_W  (24),
    .MCLK_BIT(1),
    .SCL_BIT (4)
  ) dut (
    .clk     (clk),
    .RST     (RST),
    .loopback(loopback),
    .lft_in  (lft_in),
    .rht_in  (rht_in),
    .lft_out (lft_out),
    .rht_out (rht_out),
    .valid   (valid),
    .MCLK    (MCLK),
    .SCL     (SCL),
    .LRCLK   (LRCLK),
    .RSTn    (RSTn),
    .SDin    (SDin),
    .SDout   (SDout)
  );

  always #10 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to posedge+1 of the given cycle (cycle 0 = first cycle with RST low).
  task automatic waitUntil(input int target);
    while (cyc < target) begin
      @(posedge clk);
      cyc++;
    end
    #1;
  endtask

  task automatic applyStimulus(input int code);
    case (code)
      1: loopback = 1'b1;
      2: begin
        loopback = 1'b0;
        lft_in   = 24'h0F0F0F;
        rht_in   = 24'h800001;
        codecL   = 24'hC00003;
        codecR   = 24'h7FFFFE;
      end
      default: ;
    endcase
  endtask

  // Sample SDin in the middle of every slot of one frame; optionally apply a
  // stimulus change at frame offset 500.
  task automatic decodeFrame(input int start, input int action,
                             output logic [23:0] l, output logic [23:0] r, output logic z);
    l = '0;
    r = '0;
    z = 1'b0;
    for (int h = 0; h < 2; h++) begin
      for (int s = 0; s < 32; s++) begin
        if (action != 0 && h == 0 && s == 16) begin
          waitUntil(start + 500);
          applyStimulus(action);
        end
        waitUntil(start + h * 1024 + s * 32 + 8);
        if (s >= 1 && s <= 24) begin
          if (h == 0) l = {l[22:0], SDin};
          else        r = {r[22:0], SDin};
        end else begin
          z = z | SDin;
        end
      end
    end
  endtask

  // Frame-level model: c counts clocks since reset release. It also acts as
  // the codec, driving SDout MSB-first into slots 1..24 of each half.
  int          mC, mF, mHalf, mSlot, mClk;
  logic [23:0] mFrameL, mFrameR, mCurL, mCurR, mPendL, mPendR, mExpL, mExpR;
  logic        mExpValid, mExpSd;

  initial begin : compareProc
    mC = 0;
    mFrameL = '0; mFrameR = '0; mCurL = '0; mCurR = '0;
    mPendL = '0; mPendR = '0; mExpL = '0; mExpR = '0;
    SDout = 1'b0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      mF    = mC % 2048;
      mHalf = mF / 1024;
      mSlot = (mF % 1024) / 32;
      if (mF == 0) begin
        mFrameL = codecL;
        mFrameR = codecR;
        mCurL   = mPendL;
        mCurR   = mPendR;
      end
      mExpValid = (mF == 1809) && (mC >= 2048);
      if (mExpValid) begin
        mExpL = mFrameL;
        mExpR = mFrameR;
      end
      mExpSd = 1'b0;
      if (mSlot >= 1 && mSlot <= 24) mExpSd = mHalf ? mCurR[24 - mSlot] : mCurL[24 - mSlot];
      mClk = ((mC / 2) % 2) * 8 + ((mC / 16) % 2) * 4 + ((mC / 1024) % 2) * 2 + ((mC >= 2048) ? 1 : 0);

      checkOutput("clk_rstn", {28'd0, MCLK, SCL, LRCLK, RSTn}, mClk);
      checkOutput("valid", {31'd0, valid}, {31'd0, mExpValid});
      checkOutput("lft_out", {8'd0, lft_out}, {8'd0, mExpL});
      checkOutput("rht_out", {8'd0, rht_out}, {8'd0, mExpR});
      checkOutput("sdin", {31'd0, SDin}, {31'd0, mExpSd});

      if (mF == 1808) begin
        mPendL = loopback ? mFrameL : lft_in;
        mPendR = loopback ? mFrameR : rht_in;
      end

      SDout = 1'b0;
      if (mSlot >= 1 && mSlot <= 24) SDout = mHalf ? mFrameR[24 - mSlot] : mFrameL[24 - mSlot];

      if (RST) begin
        mC = 0;
        mFrameL = '0; mFrameR = '0; mCurL = '0; mCurR = '0;
        mPendL = '0; mPendR = '0; mExpL = '0; mExpR = '0;
      end else begin
        mC++;
      end
    end
  end

  logic [23:0] decL, decR;
  logic        decZ;

  initial begin : mainProc
    RST      = 1'b1;
    loopback = 1'b0;
    lft_in   = 24'h123456;
    rht_in   = 24'hFEDCBA;
    codecL   = 24'hA5A5A5;
    codecR   = 24'h5A5A5A;

    repeat (5) @(posedge clk);
    #1;
    checkOutput("reset_pins", {26'd0, MCLK, SCL, LRCLK, RSTn, SDin, valid}, 32'd0);
    checkOutput("reset_lft", {8'd0, lft_out}, 32'd0);
    checkOutput("reset_rht", {8'd0, rht_out}, 32'd0);
    RST = 1'b0;
    cyc = 0;

    waitUntil(1809);
    checkOutput("first_frame_no_valid", {31'd0, valid}, 32'd0);
    waitUntil(2047);
    checkOutput("rstn_low_2047", {31'd0, RSTn}, 32'd0);
    waitUntil(2048);
    checkOutput("rstn_high_2048", {31'd0, RSTn}, 32'd1);
    waitUntil(2048 + 1808);
    checkOutput("valid_before", {31'd0, valid}, 32'd0);
    waitUntil(2048 + 1809);
    checkOutput("valid_first", {31'd0, valid}, 32'd1);
    checkOutput("rx_lft", {8'd0, lft_out}, 32'h00A5A5A5);
    checkOutput("rx_rht", {8'd0, rht_out}, 32'h005A5A5A);
    waitUntil(2048 + 1810);
    checkOutput("valid_after", {31'd0, valid}, 32'd0);

    // Frame 2: parallel transmit words; loopback raised mid-frame.
    decodeFrame(4096, 1, decL, decR, decZ);
    checkOutput("tx_lft_f2", {8'd0, decL}, 32'h00123456);
    checkOutput("tx_rht_f2", {8'd0, decR}, 32'h00FEDCBA);
    checkOutput("tx_pad_f2", {31'd0, decZ}, 32'd0);

    // Frame 3: loopback words; loopback dropped mid-frame has no effect yet.
    decodeFrame(6144, 2, decL, decR, decZ);
    checkOutput("loop_lft_f3", {8'd0, decL}, 32'h00A5A5A5);
    checkOutput("loop_rht_f3", {8'd0, decR}, 32'h005A5A5A);
    checkOutput("loop_pad_f3", {31'd0, decZ}, 32'd0);

    // Frame 4: back to the (new) parallel words.
    decodeFrame(8192, 0, decL, decR, decZ);
    checkOutput("tx_lft_f4", {8'd0, decL}, 32'h000F0F0F);
    checkOutput("tx_rht_f4", {8'd0, decR}, 32'h00800001);
    checkOutput("tx_pad_f4", {31'd0, decZ}, 32'd0);
    waitUntil(10217);
    checkOutput("rx_lft_f4", {8'd0, lft_out}, 32'h00C00003);
    checkOutput("rx_rht_f4", {8'd0, rht_out}, 32'h007FFFFE);
    waitUntil(10220);
    loopback = 1'b1;

    // Mid-frame reset at frame 5 offset 1200.
    waitUntil(10240 + 1200);
    RST = 1'b1;
    waitUntil(10240 + 1201);
    RST = 1'b0;
    cyc = 0;
    checkOutput("midrst_lft", {8'd0, lft_out}, 32'd0);
    checkOutput("midrst_rstn", {31'd0, RSTn}, 32'd0);
    waitUntil(1809);
    checkOutput("midrst_no_valid", {31'd0, valid}, 32'd0);
    checkOutput("midrst_lft_hold", {8'd0, lft_out}, 32'd0);
    waitUntil(2047);
    checkOutput("midrst_rstn_low", {31'd0, RSTn}, 32'd0);
    waitUntil(2048);
    checkOutput("midrst_rstn_high", {31'd0, RSTn}, 32'd1);
    waitUntil(2048 + 1809);
    checkOutput("midrst_valid", {31'd0, valid}, 32'd1);
    checkOutput("midrst_rx_lft", {8'd0, lft_out}, 32'h00C00003);
    checkOutput("midrst_rx_rht", {8'd0, rht_out}, 32'h007FFFFE);
    waitUntil(2048 + 1900);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
